sar_sequencer: RTL and testbench
================================

# sar_sequencer

Conversion sequencer for the SAR ADC. It starts a conversion on request and drives the sample switch. It then runs the MSB-first successive-approximation search against the comparator and presents the result on a valid/ready handshake. It also emits the thermometer phase vector that `phase_sum` reduces to the current step count for the analog timing and debug logic.

## Interface
- `BIT_WIDTH`, 10, result resolution in bits
- `PHASE_WIDTH`, 11, phase vector width; must equal `BIT_WIDTH`+1
- `SAMPLE_CYCLES`, 2, length of the sample phase in clocks; minimum 1
- `clk_i`  in  1  single clock; all logic is rising-edge
- `rst_n_i`  in  1  reset, asynchronous assert, active-low
- `start_i`  in  1  conversion request, sampled in IDLE only
- `cmp_i`  in  1  comparator decision: 1 means Vin >= DAC
- `ready_i`  in  1  consumer accepts `data_o`
- `sample_o`  out  1  sample switch enable
- `dac_o`  out  `BIT_WIDTH`  trial code to the capacitive DAC
- `phase_o`  out  `PHASE_WIDTH`  thermometer of the current phase
- `data_o`  out  `BIT_WIDTH`  conversion result
- `valid_o`  out  1  `data_o` is valid
- `busy_o`  out  1  high in every state except IDLE

## Operation
- States and transitions:
  - IDLE -> SAMPLE when `start_i`=1.
  - SAMPLE -> CONV after `SAMPLE_CYCLES` clocks.
  - CONV -> HOLD after `BIT_WIDTH` clocks.
  - HOLD -> IDLE when `ready_i`=1.
- SAMPLE:
  - `sample_o`=1.
  - `dac_o`=0.
  - A down-counter loads `SAMPLE_CYCLES`-1 on entry.
- CONV step j (j=0..`BIT_WIDTH`-1):
  - `dac_o` = bits already decided, plus a trial 1 at bit `BIT_WIDTH`-1-j, with all lower bits 0.
  - `cmp_i` is registered at the end of the step.
  - If `cmp_i`=1, the trial bit is kept; if 0, it is cleared.
- End of CONV:
  - The final code loads into `data_o`.
  - `valid_o` is set on entry to HOLD.
- HOLD:
  - `data_o` and `valid_o` hold stable until `ready_i`=1.
  - Handshake completes on any edge where `valid_o` and `ready_i` are both 1.
  - `valid_o` clears on that edge.
- `phase_o` (popcount tracks progress):
  - IDLE: all zero.
  - SAMPLE: bit 0 set.
  - CONV step j: bits 0..j+1 set.
  - HOLD: all ones.
- `start_i` outside IDLE is ignored; requests are not queued.
- `start_i` and the HOLD handshake on the same edge: the FSM returns to IDLE, and the start is lost.
- `cmp_i` is used only in CONV; it is don't-care elsewhere.

## Timing
- Reset values:
  - State IDLE.
  - `sample_o`=0.
  - `dac_o`=0.
  - `phase_o`=0.
  - `data_o`=0.
  - `valid_o`=0.
  - `busy_o`=0.
- Reset asserted mid-conversion clears all outputs immediately (asynchronously). Partial results are discarded.
- Let `start_i` be sampled at edge 0. Then:
  - `sample_o` is high for edges 1..`SAMPLE_CYCLES`.
  - CONV occupies the next `BIT_WIDTH` cycles.
  - `valid_o` rises `SAMPLE_CYCLES`+`BIT_WIDTH`+1 edges after edge 0, i.e. edge 13 at defaults.
- `dac_o` changes only at step boundaries. `cmp_i` must settle within one clock of a `dac_o` change.
- With `ready_i` held at 1, the minimum conversion period is `SAMPLE_CYCLES`+`BIT_WIDTH`+2 clocks; the +2 covers the HOLD cycle and the return to IDLE.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `SAR_SEQ_CONT_EN` defined:
  - Adds input `cont_i`.
  - If `cont_i`=1 when the HOLD handshake completes, the FSM goes directly to SAMPLE and skips IDLE. Back-to-back period is `SAMPLE_CYCLES`+`BIT_WIDTH`+1 clocks.
  - `busy_o` stays high between conversions.
- `SAR_SEQ_CONT_EN` undefined:
  - No `cont_i` port.
  - HOLD always returns to IDLE, and every conversion needs its own `start_i`.

## Test plan
- Reset then idle: all outputs 0. `start_i`=0 for 20 clocks -> state stays IDLE and `phase_o`=0.
- Ideal comparator with Vin code 0x2A5, `ready_i`=1 -> `data_o`=0x2A5 with `valid_o` at edge 13. `dac_o` trial sequence starts 0x200, 0x300, 0x280, 0x2C0, ...
- Extreme codes: Vin 0x000 -> `data_o`=0x000; Vin 0x3FF -> `data_o`=0x3FF. `phase_o` popcount reads 0, 1, 2..11, 11 across the conversion.
- Backpressure: `ready_i`=0 for 5 clocks after `valid_o` -> `data_o`/`valid_o` stable; `start_i` pulses ignored; handshake on the 6th clock -> IDLE next edge.
- Reset mid-conversion: `rst_n_i` low during CONV step 4 -> all outputs 0 immediately. A new conversion of 0x155 then yields 0x155.
- `SAR_SEQ_CONT_EN` with `cont_i`=1 and codes 0x123 then 0x321 -> two results 13 clocks apart with no IDLE cycle between them.

Source files
------------

// File: rtl/sar_sequencer.sv
// sar_sequencer: SAR ADC conversion sequencer.
// The sequencer samples the input, runs an MSB-first successive-approximation
// search against the comparator, and presents the result on a valid/ready
// handshake. It also drives a thermometer phase vector that shows progress.
// Optional feature macro: SAR_SEQ_CONT_EN adds cont_i. When cont_i is set,
// a completed handshake restarts sampling directly and does not pass through IDLE.
// PHASE_WIDTH must equal BIT_WIDTH+1, and SAMPLE_CYCLES must be at least 1.
module sar_sequencer #(
   parameter int BIT_WIDTH     = 10,
   parameter int PHASE_WIDTH   = 11,
   parameter int SAMPLE_CYCLES = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   start_i,
`ifdef SAR_SEQ_CONT_EN
   input  logic                   cont_i,
`endif
   input  logic                   cmp_i,
   input  logic                   ready_i,
   output logic                   sample_o,
   output logic [BIT_WIDTH-1:0]   dac_o,
   output logic [PHASE_WIDTH-1:0] phase_o,
   output logic [BIT_WIDTH-1:0]   data_o,
   output logic                   valid_o,
   output logic                   busy_o
);

   localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
   localparam int IW = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_CONV,
      ST_HOLD
   } state_t;

   state_t                 state_reg, state_next;
   logic [CW-1:0]          sample_cnt_reg, sample_cnt_next;
   logic [IW-1:0]          bit_idx_reg, bit_idx_next;
   logic [BIT_WIDTH-1:0]   dac_reg, dac_next;
   logic [PHASE_WIDTH-1:0] phase_reg, phase_next;
   logic [BIT_WIDTH-1:0]   data_reg, data_next;
   logic                   valid_reg, valid_next;
   logic                   sample_reg, sample_next;
   logic                   busy_reg, busy_next;

   logic [BIT_WIDTH-1:0]   trial_bit;
   logic [BIT_WIDTH-1:0]   kept_code;
   logic                   enter_sample;
   logic                   restart;

   // The current trial bit is kept or cleared according to the comparator decision.
   always_comb begin
      trial_bit = BIT_WIDTH'(1) << bit_idx_reg;
      kept_code = cmp_i ? dac_reg : (dac_reg & ~trial_bit);
   end

`ifdef SAR_SEQ_CONT_EN
   assign restart = cont_i;
`else
   assign restart = 1'b0;
`endif

   // Next-state and next-output logic. Every output is registered, so no
   // combinational path runs from an input to an output.
   always_comb begin
      state_next      = state_reg;
      sample_cnt_next = sample_cnt_reg;
      bit_idx_next    = bit_idx_reg;
      dac_next        = dac_reg;
      phase_next      = phase_reg;
      data_next       = data_reg;
      valid_next      = valid_reg;
      sample_next     = sample_reg;
      enter_sample    = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (start_i) begin
               enter_sample = 1'b1;
            end
         end
         ST_SAMPLE: begin
            if (sample_cnt_reg == '0) begin
               state_next   = ST_CONV;
               sample_next  = 1'b0;
               dac_next     = BIT_WIDTH'(1) << (BIT_WIDTH - 1);
               bit_idx_next = IW'(BIT_WIDTH - 1);
               phase_next   = PHASE_WIDTH'(3);
            end else begin
               sample_cnt_next = sample_cnt_reg - CW'(1);
            end
         end
         ST_CONV: begin
            if (bit_idx_reg == '0) begin
               state_next = ST_HOLD;
               data_next  = kept_code;
               valid_next = 1'b1;
               dac_next   = '0;
               phase_next = '1;
            end else begin
               dac_next     = kept_code | (trial_bit >> 1);
               bit_idx_next = bit_idx_reg - IW'(1);
               phase_next   = {phase_reg[PHASE_WIDTH-2:0], 1'b1};
            end
         end
         ST_HOLD: begin
            if (valid_reg && ready_i) begin
               valid_next = 1'b0;
               if (restart) begin
                  enter_sample = 1'b1;
               end else begin
                  state_next = ST_IDLE;
                  phase_next = '0;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (enter_sample) begin
         state_next      = ST_SAMPLE;
         sample_next     = 1'b1;
         dac_next        = '0;
         phase_next      = PHASE_WIDTH'(1);
         sample_cnt_next = CW'(SAMPLE_CYCLES - 1);
      end

      busy_next = (state_next != ST_IDLE);
   end

   // State and output registers. Reset clears everything asynchronously.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg      <= ST_IDLE;
         sample_cnt_reg <= '0;
         bit_idx_reg    <= '0;
         dac_reg        <= '0;
         phase_reg      <= '0;
         data_reg       <= '0;
         valid_reg      <= 1'b0;
         sample_reg     <= 1'b0;
         busy_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         sample_cnt_reg <= sample_cnt_next;
         bit_idx_reg    <= bit_idx_next;
         dac_reg        <= dac_next;
         phase_reg      <= phase_next;
         data_reg       <= data_next;
         valid_reg      <= valid_next;
         sample_reg     <= sample_next;
         busy_reg       <= busy_next;
      end
   end

   assign sample_o = sample_reg;
   assign dac_o    = dac_reg;
   assign phase_o  = phase_reg;
   assign data_o   = data_reg;
   assign valid_o  = valid_reg;
   assign busy_o   = busy_reg;

endmodule

// File: tb/tb_sar_sequencer.sv
// tb_sar_sequencer: directed bench for sar_sequencer at default parameters.
// An ideal comparator is modelled as (vin_code >= dac_o).
// Each conversion is traced by its observation index n. Index n is the value
// seen at the negedge just before posedge n. Posedge 0 is the edge that samples start_i.
module tb_sar_sequencer;

   logic       clk_i = 1'b0;
   logic       rst_n_i;
   logic       start_i;
   logic       cmp_i;
   logic       ready_i;
   logic       sample_o;
   logic [9:0] dac_o;
   logic [10:0] phase_o;
   logic [9:0] data_o;
   logic       valid_o;
   logic       busy_o;
`ifdef SAR_SEQ_CONT_EN
   logic       cont_i;
`endif

   logic [9:0] vin_code;
   int         checks = 0;
   int         errors = 0;

   always #5 clk_i = ~clk_i;

   assign cmp_i = (vin_code >= dac_o);

   sar_sequencer #(
      .BIT_WIDTH     (10),
      .PHASE_WIDTH   (11),
      .SAMPLE_CYCLES (2)
   ) dut (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .start_i  (start_i),
`ifdef SAR_SEQ_CONT_EN
      .cont_i   (cont_i),
`endif
      .cmp_i    (cmp_i),
      .ready_i  (ready_i),
      .sample_o (sample_o),
      .dac_o    (dac_o),
      .phase_o  (phase_o),
      .data_o   (data_o),
      .valid_o  (valid_o),
      .busy_o   (busy_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected trial code at CONV step j, assuming an ideal comparator.
   function automatic int exp_dac(input int vin, input int j);
      int b;
      b = 9 - j;
      return ((vin >> (b + 1)) << (b + 1)) | (1 << b);
   endfunction

   // Expected phase thermometer at observation index n (n = 1..13).
   function automatic int exp_phase(input int n);
      int pop;
      if (n <= 2) pop = 1;
      else if (n <= 12) pop = n - 1;
      else pop = 11;
      return (1 << pop) - 1;
   endfunction

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_sample"}, sample_o, 0);
      check_eq({tag, "_dac"}, dac_o, 0);
      check_eq({tag, "_phase"}, phase_o, 0);
      check_eq({tag, "_data"}, data_o, 0);
      check_eq({tag, "_valid"}, valid_o, 0);
      check_eq({tag, "_busy"}, busy_o, 0);
   endtask

   // Trace one conversion from a start pulse. stall is the number of clocks
   // that ready_i stays low after valid_o rises (0 or 5).
   task automatic run_conv(input logic [9:0] vin, input int stall);
      vin_code = vin;
      ready_i  = (stall == 0);
      @(negedge clk_i);
      start_i = 1'b1;
      for (int n = 1; n <= 13; n++) begin
         @(negedge clk_i);
         if (n == 1) start_i = 1'b0;
         check_eq($sformatf("sample_n%0d", n), sample_o, (n <= 2));
         check_eq($sformatf("busy_n%0d", n), busy_o, 1);
         check_eq($sformatf("valid_n%0d", n), valid_o, (n == 13));
         check_eq($sformatf("phase_n%0d", n), phase_o, exp_phase(n));
         if (n <= 2) check_eq($sformatf("dac_n%0d", n), dac_o, 0);
         else if (n <= 12) check_eq($sformatf("dac_n%0d", n), dac_o, exp_dac(int'(vin), n - 3));
      end
      check_eq("data_result", data_o, vin);
      if (stall > 0) begin
         for (int n = 14; n <= 17; n++) begin
            @(negedge clk_i);
            start_i = (n <= 16);
            check_eq($sformatf("hold_valid_n%0d", n), valid_o, 1);
            check_eq($sformatf("hold_data_n%0d", n), data_o, vin);
            check_eq($sformatf("hold_phase_n%0d", n), phase_o, 11'h7FF);
         end
         @(negedge clk_i);
         start_i = 1'b0;
         ready_i = 1'b1;
         check_eq("hold_valid_n18", valid_o, 1);
         check_eq("hold_data_n18", data_o, vin);
      end
      @(negedge clk_i);
      check_eq("post_valid", valid_o, 0);
      check_eq("post_busy", busy_o, 0);
      check_eq("post_phase", phase_o, 0);
      check_eq("post_sample", sample_o, 0);
      check_eq("post_data", data_o, vin);
      $display("conv vin=0x%03h stall=%0d data=0x%03h", vin, stall, data_o);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n_i  = 1'b0;
      start_i  = 1'b0;
      ready_i  = 1'b1;
      vin_code = '0;
`ifdef SAR_SEQ_CONT_EN
      cont_i   = 1'b0;
`endif
      repeat (3) @(negedge clk_i);
      check_all_zero("reset");
      rst_n_i = 1'b1;

      // Keep the design idle for 20 clocks.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         check_eq($sformatf("idle_busy_%0d", i), busy_o, 0);
         check_eq($sformatf("idle_phase_%0d", i), phase_o, 0);
         check_eq($sformatf("idle_sample_%0d", i), sample_o, 0);
      end
      $display("idle 20 clocks busy=%0d phase=0x%03h", busy_o, phase_o);

      run_conv(10'h2A5, 0);
      run_conv(10'h000, 0);
      run_conv(10'h3FF, 0);
      run_conv(10'h0F0, 5);

      // Assert reset during CONV step 4 (n=7). The outputs must clear without waiting for a clock edge.
      vin_code = 10'h2A5;
      ready_i  = 1'b1;
      @(negedge clk_i);
      start_i = 1'b1;
      for (int n = 1; n <= 7; n++) begin
         @(negedge clk_i);
         if (n == 1) start_i = 1'b0;
      end
      check_eq("pre_rst_busy", busy_o, 1);
      check_eq("pre_rst_dac", dac_o, exp_dac(10'h2A5, 4));
      rst_n_i = 1'b0;
      #1;
      check_all_zero("midrst");
      $display("reset mid-conversion busy=%0d phase=0x%03h", busy_o, phase_o);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      run_conv(10'h155, 0);

`ifdef SAR_SEQ_CONT_EN
      // Continuous mode: the second conversion starts from the handshake edge.
      cont_i   = 1'b1;
      ready_i  = 1'b1;
      vin_code = 10'h123;
      @(negedge clk_i);
      start_i = 1'b1;
      for (int n = 1; n <= 26; n++) begin
         @(negedge clk_i);
         if (n == 1) start_i = 1'b0;
         check_eq($sformatf("cont_busy_n%0d", n), busy_o, 1);
         check_eq($sformatf("cont_valid_n%0d", n), valid_o, (n == 13) || (n == 26));
         if (n == 13) begin
            check_eq("cont_data0", data_o, 10'h123);
            $display("cont conv vin=0x123 data=0x%03h", data_o);
            vin_code = 10'h321;
         end
         if (n == 14 || n == 15) check_eq($sformatf("cont_sample_n%0d", n), sample_o, 1);
         if (n == 26) begin
            check_eq("cont_data1", data_o, 10'h321);
            $display("cont conv vin=0x321 data=0x%03h", data_o);
            cont_i = 1'b0;
         end
      end
      @(negedge clk_i);
      check_eq("cont_end_busy", busy_o, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
